// File: rtl/gate_codes_pkg.sv
// Shared 2-bit gate code definitions for the encoder/decoder pair, plus the
// decoder FSM state type and the code-to-line mapping.
package gate_codes_pkg;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_C    = 2'b01;
  localparam logic [1:0] CODE_B    = 2'b10;
  localparam logic [1:0] CODE_A    = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Returns the one-hot line vector {a, b, c} for a code; CODE_NONE maps to zero.
  function automatic logic [2:0] decode_code(input logic [1:0] code);
    logic [2:0] lines;
    lines = 3'b000;
    case (code)
      CODE_A:  lines = 3'b100;
      CODE_B:  lines = 3'b010;
      CODE_C:  lines = 3'b001;
      default: lines = 3'b000;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/decoder_gate.sv
// Receive-side gate decoder: accepts a 2-bit code over valid/ready, stretches the
// decoded one-hot line to HOLD cycles, and keeps saturating per-line event counts.
module decoder_gate
  import gate_codes_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       inp,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);

  localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(HOLD - 1);

  // Handshake: a code transfers on any rising edge where in_valid && in_ready;
  // while in_ready is low the source must hold inp and in_valid unchanged.

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    line_q,  line_d;
  logic          accept;
  logic          code_nz;

  assign in_ready = (state_q == gate_codes_pkg::IDLE) || (timer_q == '0);
  assign accept   = in_valid && in_ready;
  assign code_nz  = (inp != CODE_NONE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    line_d  = line_q;
    if (state_q == gate_codes_pkg::IDLE) begin
      if (accept && code_nz) begin
        state_d = gate_codes_pkg::HOLD;
        timer_d = TIMER_RELOAD;
        line_d  = decode_code(inp);
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else if (accept && code_nz) begin
      // Back-to-back reload on the last hold cycle keeps the pulse train gapless.
      timer_d = TIMER_RELOAD;
      line_d  = decode_code(inp);
    end else begin
      state_d = gate_codes_pkg::IDLE;
      line_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= gate_codes_pkg::IDLE;
      timer_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      line_q  <= line_d;
    end
  end

  assign a_out = line_q[2];
  assign b_out = line_q[1];
  assign c_out = line_q[0];
  assign busy  = (state_q == gate_codes_pkg::HOLD);

  sat_counter #(.W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (accept && (inp == CODE_A)),
    .q     (cnt_a)
  );

  sat_counter #(.W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (accept && (inp == CODE_B)),
    .q     (cnt_b)
  );

  sat_counter #(.W(CNT_W)) u_cnt_c (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (accept && (inp == CODE_C)),
    .q     (cnt_c)
  );

endmodule

// File: tb/tb_decoder_gate.sv
// Directed bench for decoder_gate: HOLD=4/CNT_W=8 instance for timing, handshake and
// clear behaviour, plus a HOLD=1/CNT_W=2 instance for throughput and saturation.
module tb_decoder_gate;

  logic clk;
  logic rst_n;

  // Instance 1: HOLD=4, CNT_W=8
  logic       in_valid, in_ready, a_out, b_out, c_out, busy, cnt_clr;
  logic [1:0] inp;
  logic [7:0] cnt_a, cnt_b, cnt_c;

  // Instance 2: HOLD=1, CNT_W=2
  logic       in_valid2, in_ready2, a_out2, b_out2, c_out2, busy2, cnt_clr2;
  logic [1:0] inp2;
  logic [1:0] cnt_a2, cnt_b2, cnt_c2;

  int checks;
  int errors;

  decoder_gate #(.HOLD(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inp      (inp),
    .a_out    (a_out),
    .b_out    (b_out),
    .c_out    (c_out),
    .busy     (busy),
    .cnt_clr  (cnt_clr),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .cnt_c    (cnt_c)
  );

  decoder_gate #(.HOLD(1), .CNT_W(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .inp      (inp2),
    .a_out    (a_out2),
    .b_out    (b_out2),
    .c_out    (c_out2),
    .busy     (busy2),
    .cnt_clr  (cnt_clr2),
    .cnt_a    (cnt_a2),
    .cnt_b    (cnt_b2),
    .cnt_c    (cnt_c2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs driven after this see the next edge, outputs read reflect it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_lines(input string tag);
    check({tag, "_a"},    {31'd0, a_out}, 32'd0);
    check({tag, "_b"},    {31'd0, b_out}, 32'd0);
    check({tag, "_c"},    {31'd0, c_out}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy},  32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inp       = 2'b00;
    cnt_clr   = 1'b0;
    in_valid2 = 1'b0;
    inp2      = 2'b00;
    cnt_clr2  = 1'b0;

    // Reset state
    repeat (2) tick();
    check_idle_lines("rst");
    check("rst_cnt_a", {24'd0, cnt_a}, 32'd0);
    check("rst_cnt_b", {24'd0, cnt_b}, 32'd0);
    check("rst_cnt_c", {24'd0, cnt_c}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Async reset in the middle of a HOLD pulse
    in_valid = 1'b1;
    inp      = 2'b11;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_a_before", {31'd0, a_out}, 32'd1);
    check("mid_cnt_before", {24'd0, cnt_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_lines("mid_rst");
    check("mid_rst_cnt_a", {24'd0, cnt_a}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rel_a", {31'd0, a_out}, 32'd0);

    // Single a-code: a_out and busy high for exactly 4 cycles, cnt_a=1 at t+1
    in_valid = 1'b1;
    inp      = 2'b11;
    check("a_ready_t", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    inp      = 2'b00;
    check("a_cnt_t1", {24'd0, cnt_a}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("a_out_t%0d", i), {31'd0, a_out}, (i <= 4) ? 32'd1 : 32'd0);
      check($sformatf("a_busy_t%0d", i), {31'd0, busy}, (i <= 4) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end

    // b then c with in_valid held: no gap, no overlap, ready only on last hold cycle
    in_valid = 1'b1;
    inp      = 2'b10;
    tick();
    inp = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) in_valid = 1'b0;
      check($sformatf("bc_b_t%0d", i), {31'd0, b_out}, (i <= 4) ? 32'd1 : 32'd0);
      check($sformatf("bc_c_t%0d", i), {31'd0, c_out}, (i >= 5 && i <= 8) ? 32'd1 : 32'd0);
      check($sformatf("bc_rdy_t%0d", i), {31'd0, in_ready},
            (i == 4 || i >= 8) ? 32'd1 : 32'd0);
      check($sformatf("bc_onehot_t%0d", i), {30'd0, 2'(a_out + b_out + c_out)},
            (i <= 8) ? 32'd1 : 32'd0);
      if (i < 9) tick();
    end
    check("bc_cnt_b", {24'd0, cnt_b}, 32'd1);
    check("bc_cnt_c", {24'd0, cnt_c}, 32'd1);

    // Repeated 00 codes: consumed silently
    in_valid = 1'b1;
    inp      = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("none_rdy_%0d", i), {31'd0, in_ready}, 32'd1);
      check_idle_lines($sformatf("none_%0d", i));
    end
    in_valid = 1'b0;
    check("none_cnt_a", {24'd0, cnt_a}, 32'd1);
    check("none_cnt_b", {24'd0, cnt_b}, 32'd1);
    check("none_cnt_c", {24'd0, cnt_c}, 32'd1);

    // Bring cnt_c to 2, then clear on the same cycle as an accepted c-code
    in_valid = 1'b1;
    inp      = 2'b01;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("clr_pre_cnt_c", {24'd0, cnt_c}, 32'd2);
    check("clr_pre_idle", {31'd0, busy}, 32'd0);
    in_valid = 1'b1;
    inp      = 2'b01;
    cnt_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    check("clr_cnt_a", {24'd0, cnt_a}, 32'd0);
    check("clr_cnt_b", {24'd0, cnt_b}, 32'd0);
    check("clr_cnt_c", {24'd0, cnt_c}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("clr_c_t%0d", i), {31'd0, c_out}, (i <= 4) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end
    check("clr_post_cnt_c", {24'd0, cnt_c}, 32'd0);

    // HOLD=1, CNT_W=2: five consecutive a-codes, one per cycle, counter saturates at 3
    in_valid2 = 1'b1;
    inp2      = 2'b11;
    check("h1_rdy_t0", {31'd0, in_ready2}, 32'd1);
    tick();
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) in_valid2 = 1'b0;
      check($sformatf("h1_a_t%0d", i), {31'd0, a_out2}, (i <= 5) ? 32'd1 : 32'd0);
      check($sformatf("h1_cnt_t%0d", i), {30'd0, cnt_a2}, (i < 3) ? i : 32'd3);
      check($sformatf("h1_rdy_t%0d", i), {31'd0, in_ready2}, 32'd1);
      if (i < 6) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
